sine2x_inverse_search: RTL

SINE2X_INVERSE_SEARCH -- requirements
Module: sine2x_inverse_search

---
 rtl/sine2x_inverse_search.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sine2x_inverse_search.sv
// Recovers x (0..45 degrees) from an IEEE-754 double holding sin(2x), using a
// binary search over a 46-entry sin(2k deg) magnitude table with a fixed 8-cycle latency.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module sine2x_inverse_search (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [63:0]            data_in,
  output logic                   busy,
  output logic                   done,
  output logic [`DATA_WIDTH-1:0] angle_out,
  output logic [`DATA_WIDTH-1:0] alt_angle_out,
  output logic [1:0]             quadrant_out,
  output logic                   exact,
  output logic                   error
);

  localparam int DW = `DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, CHECK, SEARCH, DONE} state_t;

  localparam logic [62:0] MAX_MAG = 63'h3FF0000000000000;

  // Entry k holds the double bit pattern of sin(2k degrees); only the magnitude bits are used.
  localparam logic [63:0] SIN_TABLE [46] = '{
    $realtobits(0.0),                 $realtobits(0.03489949670250097), $realtobits(0.0697564737441253),
    $realtobits(0.10452846326765347), $realtobits(0.13917310096006544), $realtobits(0.17364817766693033),
    $realtobits(0.20791169081775931), $realtobits(0.24192189559966773), $realtobits(0.27563735581699916),
    $realtobits(0.3090169943749474),  $realtobits(0.3420201433256687),  $realtobits(0.374606593415912),
    $realtobits(0.40673664307580015), $realtobits(0.4383711467890774),  $realtobits(0.46947156278589076),
    $realtobits(0.5),                 $realtobits(0.5299192642332049),  $realtobits(0.5591929034707468),
    $realtobits(0.5877852522924731),  $realtobits(0.6156614753256583),  $realtobits(0.6427876096865393),
    $realtobits(0.6691306063588582),  $realtobits(0.6946583704589973),  $realtobits(0.7193398003386511),
    $realtobits(0.7431448254773942),  $realtobits(0.766044443118978),   $realtobits(0.7880107536067219),
    $realtobits(0.8090169943749474),  $realtobits(0.8290375725550417),  $realtobits(0.848048096156426),
    $realtobits(0.8660254037844386),  $realtobits(0.882947592858927),   $realtobits(0.898794046299167),
    $realtobits(0.9135454576426009),  $realtobits(0.9271838545667874),  $realtobits(0.9396926207859083),
    $realtobits(0.9510565162951535),  $realtobits(0.9612616959383189),  $realtobits(0.9702957262759965),
    $realtobits(0.9781476007338056),  $realtobits(0.984807753012208),   $realtobits(0.9902680687415703),
    $realtobits(0.9945218953682733),  $realtobits(0.9975640502598242),  $realtobits(0.9993908270190957),
    $realtobits(1.0)
  };

  state_t          state_q, state_d;
  logic [63:0]     latch_q, latch_d;
  logic            sign_q, sign_d;
  logic            err_q, err_d;
  logic [5:0]      lo_q, lo_d, hi_q, hi_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [DW-1:0]   angle_q, angle_d, alt_q, alt_d;
  logic [1:0]      quad_q, quad_d;
  logic            exact_q, exact_d, error_q, error_d, done_q, done_d;
  logic [5:0]      mid;
  logic [62:0]     midEntry, loEntry;

  always_comb begin
    state_d  = state_q;
    latch_d  = latch_q;
    sign_d   = sign_q;
    err_d    = err_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    angle_d  = angle_q;
    alt_d    = alt_q;
    quad_d   = quad_q;
    exact_d  = exact_q;
    error_d  = error_q;
    done_d   = 1'b0;
    mid      = 6'(({1'b0, lo_q} + {1'b0, hi_q} + 7'd1) >> 1);
    midEntry = SIN_TABLE[mid][62:0];
    loEntry  = SIN_TABLE[lo_q][62:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          latch_d = data_in;
          state_d = CHECK;
        end
      end
      // Out-of-domain inputs still walk through SEARCH with lo==hi so latency never changes.
      CHECK: begin
        sign_d  = latch_q[63];
        err_d   = latch_q[62:0] > MAX_MAG;
        lo_d    = 6'd0;
        hi_d    = (latch_q[62:0] > MAX_MAG) ? 6'd0 : 6'd45;
        cnt_d   = 3'd0;
        state_d = SEARCH;
      end
      SEARCH: begin
        if (lo_q != hi_q) begin
          if (midEntry <= latch_q[62:0]) lo_d = mid;
          else                           hi_d = mid - 6'd1;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          cnt_d   = 3'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        quad_d  = sign_q ? 2'd2 : 2'd0;
        error_d = err_q;
        exact_d = !err_q && (loEntry == latch_q[62:0]);
        angle_d = err_q ? '0 : DW'(lo_q);
        alt_d   = err_q ? '0 : DW'(7'd90 - {1'b0, lo_q});
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      latch_q <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      angle_q <= '0;
      alt_q   <= '0;
      quad_q  <= '0;
      exact_q <= 1'b0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      angle_q <= angle_d;
      alt_q   <= alt_d;
      quad_q  <= quad_d;
      exact_q <= exact_d;
      error_q <= error_d;
      done_q  <= done_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign angle_out     = angle_q;
  assign alt_angle_out = alt_q;
  assign quadrant_out  = quad_q;
  assign exact         = exact_q;
  assign error         = error_q;

endmodule
